lsu_mod: RTL and testbench

Load/store unit on the execute-to-memory path. It takes the effective address produced by the ALU stage for LOAD/STORE instructions, plus rs2 store data and funct3. It runs a request/acknowledge transaction on the data-memory port with byte-lane steering. For loads, it returns an aligned, sign- or zero-extended result for register writeback. While a transaction is outstanding it holds `ready` low so the core stalls.

---
 rtl/lsu_mod.sv | 165 ++++++++++++++++
 tb/tb_lsu_mod.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mod.sv
// Load/store unit: one request/acknowledge data-memory transaction per LOAD/STORE, with byte-lane steering and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word ops complete at once with `misalign` instead of touching memory.
module lsu_mod #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       ld_data,
    output logic              misalign,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                isStore_q;
    logic [2:0]          funct3_q;
    logic [1:0]          off_q;
    logic                done_q;
    logic                misalign_q;
    logic [31:0]         ldData_q;
    logic                dmemReq_q;
    logic                dmemWe_q;
    logic [ADDR_W-1:0]   dmemAddr_q;
    logic [3:0]          dmemBe_q;
    logic [31:0]         dmemWdata_q;

    logic                isByte;
    logic                isHalf;
    logic [1:0]          off_d;
    logic [3:0]          be_d;
    logic [31:0]         wdata_d;
    logic                trap_d;
    logic [7:0]          byteSel;
    logic [15:0]         halfSel;
    logic [31:0]         ldExt;

    // funct3[1:0] alone gives the access width for loads and stores; 11 falls through to word.
    always_comb begin
        isByte  = (funct3[1:0] == 2'b00);
        isHalf  = (funct3[1:0] == 2'b01);
        off_d   = 2'b00;
        be_d    = 4'b1111;
        wdata_d = wdata;
        if (isByte) begin
            off_d   = addr[1:0];
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
        end else if (isHalf) begin
            off_d   = {addr[1], 1'b0};
            be_d    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata[15:0]}};
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_d = (isHalf && addr[0]) || (!isByte && !isHalf && (addr[1:0] != 2'b00));
`else
    assign trap_d = 1'b0;
`endif

    always_comb begin
        case (off_q)
            2'd1:    byteSel = dmem_rdata[15:8];
            2'd2:    byteSel = dmem_rdata[23:16];
            2'd3:    byteSel = dmem_rdata[31:24];
            default: byteSel = dmem_rdata[7:0];
        endcase
        halfSel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   ldExt = funct3_q[2] ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
            2'b01:   ldExt = funct3_q[2] ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
            default: ldExt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            isStore_q   <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            ldData_q    <= 32'b0;
            dmemReq_q   <= 1'b0;
            dmemWe_q    <= 1'b0;
            dmemAddr_q  <= '0;
            dmemBe_q    <= 4'b0000;
            dmemWdata_q <= 32'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q     <= 1'b0;
                    misalign_q <= 1'b0;
                    ldData_q   <= 32'b0;
                    if (valid) begin
                        if (trap_d) begin
                            // Trapped op never reaches memory; ld_data stays 0.
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            isStore_q   <= is_store;
                            funct3_q    <= funct3;
                            off_q       <= off_d;
                            dmemReq_q   <= 1'b1;
                            dmemWe_q    <= is_store;
                            dmemAddr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            dmemBe_q    <= be_d;
                            dmemWdata_q <= wdata_d;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        state_q   <= DONE;
                        dmemReq_q <= 1'b0;
                        dmemWe_q  <= 1'b0;
                        done_q    <= 1'b1;
                        ldData_q  <= isStore_q ? 32'b0 : ldExt;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    misalign_q <= 1'b0;
                    ldData_q   <= 32'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready      = (state_q == IDLE);
    assign done       = done_q;
    assign misalign   = misalign_q;
    assign ld_data    = ldData_q;
    assign dmem_req   = dmemReq_q;
    assign dmem_we    = dmemWe_q;
    assign dmem_addr  = dmemAddr_q;
    assign dmem_be    = dmemBe_q;
    assign dmem_wdata = dmemWdata_q;

endmodule

// File: tb/tb_lsu_mod.sv
// Self-checking bench for lsu_mod: table of load/store vectors with a scoreboard on `done`, plus reset/ack/valid corner sequences.
module tb_lsu_mod;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] ld_data;
    logic        misalign;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic        trap;
        logic [31:0] eAddr;
        logic [3:0]  eBe;
        logic [31:0] eWdata;
        logic [31:0] eLd;
        logic        noise;
    } vec_t;

    vec_t vecs[14];
    vec_t expQ[$];
    vec_t monE;
    int   total;
    int   bad;

    lsu_mod #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .ld_data   (ld_data),
        .misalign  (misalign),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_be   (dmem_be),
        .dmem_wdata(dmem_wdata),
        .dmem_ack  (dmem_ack),
        .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input int dly,
                                input logic trap, input logic [31:0] eAddr, input logic [3:0] eBe,
                                input logic [31:0] eWdata, input logic [31:0] eLd, input logic noise);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.dly = dly;
        v.trap = trap; v.eAddr = eAddr; v.eBe = eBe; v.eWdata = eWdata;
        v.eLd = trap ? 32'h0 : eLd; v.noise = noise;
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedDone: got done=1 want done=0 at %0t", $time);
            end else begin
                monE = expQ.pop_front();
                checkOutput("ldData", ld_data, monE.eLd);
                checkOutput("misalign", {31'b0, misalign}, {31'b0, monE.trap});
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        checkOutput({tag, ".readyIdle"}, {31'b0, ready}, 32'd1);
        expQ.push_back(v);
        valid    = 1'b1;
        is_store = v.st;
        funct3   = v.f3;
        addr     = v.addr;
        wdata    = v.wdata;
        @(negedge clk);
        valid = 1'b0;
        if (v.trap) begin
            checkOutput({tag, ".noReq"}, {31'b0, dmem_req}, 32'd0);
        end else begin
            for (int i = 0; i <= v.dly; i++) begin
                checkOutput({tag, ".req"}, {31'b0, dmem_req}, 32'd1);
                checkOutput({tag, ".ready"}, {31'b0, ready}, 32'd0);
                checkOutput({tag, ".addr"}, dmem_addr, v.eAddr);
                checkOutput({tag, ".be"}, {28'b0, dmem_be}, {28'b0, v.eBe});
                checkOutput({tag, ".we"}, {31'b0, dmem_we}, {31'b0, v.st});
                checkOutput({tag, ".doneLow"}, {31'b0, done}, 32'd0);
                if (v.st) checkOutput({tag, ".wdata"}, dmem_wdata, v.eWdata);
                if (v.noise) begin
                    valid    = 1'b1;
                    is_store = ~v.st;
                    funct3   = 3'b010;
                    addr     = 32'h0000_0900;
                    wdata    = 32'h1357_9BDF;
                end
                if (i == v.dly) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = v.rdata;
                end
                @(negedge clk);
                dmem_ack   = 1'b0;
                dmem_rdata = 32'h5A5A_A5A5;
            end
            valid = 1'b0;
        end
        checkOutput({tag, ".done"}, {31'b0, done}, 32'd1);
        checkOutput({tag, ".reqOffInDone"}, {30'b0, dmem_req, dmem_we}, 32'd0);
        @(negedge clk);
        checkOutput({tag, ".donePulse"}, {31'b0, done}, 32'd0);
        checkOutput({tag, ".ldZero"}, ld_data, 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        valid = 1'b0;
        is_store = 1'b0;
        funct3 = 3'b000;
        addr = 32'h0;
        wdata = 32'h0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("rst.ready", {31'b0, ready}, 32'd1);
        checkOutput("rst.flags", {28'b0, done, misalign, dmem_req, dmem_we}, 32'd0);
        checkOutput("rst.ldData", ld_data, 32'd0);
        checkOutput("rst.addr", dmem_addr, 32'd0);
        checkOutput("rst.be", {28'b0, dmem_be}, 32'd0);
        checkOutput("rst.wdata", dmem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //           st    f3      addr          wdata         rdata         dly trap  eAddr         eBe      eWdata        eLd           noise
        vecs[0]  = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0);
        vecs[1]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
        vecs[2]  = mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 1, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
        vecs[3]  = mk(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,       3, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
        vecs[4]  = mk(1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h1234_F00D, 0, TRAP, 32'h0000_0100, 4'b0011, 32'h0,        32'hFFFF_F00D, 1'b0);
        vecs[5]  = mk(1'b1, 3'b000, 32'h0000_0011, 32'h1234_5678, 32'h0,       0, 1'b0, 32'h0000_0010, 4'b0010, 32'h7878_7878, 32'h0,        1'b0);
        vecs[6]  = mk(1'b0, 3'b101, 32'h0000_0302, 32'h0,        32'h8001_7FFF, 0, 1'b0, 32'h0000_0300, 4'b1100, 32'h0,        32'h0000_8001, 1'b0);
        vecs[7]  = mk(1'b0, 3'b001, 32'h0000_0302, 32'h0,        32'h8001_7FFF, 2, 1'b0, 32'h0000_0300, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0);
        vecs[8]  = mk(1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,       1, 1'b0, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0);
        vecs[9]  = mk(1'b0, 3'b000, 32'h0000_0041, 32'h0,        32'h0000_7F00, 0, 1'b0, 32'h0000_0040, 4'b0010, 32'h0,        32'h0000_007F, 1'b0);
        vecs[10] = mk(1'b0, 3'b110, 32'h0000_0500, 32'h0,        32'h0102_0304, 0, 1'b0, 32'h0000_0500, 4'b1111, 32'h0,        32'h0102_0304, 1'b0);
        vecs[11] = mk(1'b1, 3'b011, 32'h0000_0600, 32'h1122_3344, 32'h0,       0, 1'b0, 32'h0000_0600, 4'b1111, 32'h1122_3344, 32'h0,        1'b0);
        vecs[12] = mk(1'b0, 3'b010, 32'h0000_0703, 32'h0,        32'h7654_3210, 0, TRAP, 32'h0000_0700, 4'b1111, 32'h0,        32'h7654_3210, 1'b0);
        vecs[13] = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hA5A5_0F0F, 2, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hA5A5_0F0F, 1'b1);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Ack while idle must not start or finish anything.
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        checkOutput("idleAck.req", {31'b0, dmem_req}, 32'd0);
        checkOutput("idleAck.ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        checkOutput("idleAck.done", {31'b0, done}, 32'd0);

        // Reset in REQ with an ack in the same cycle: reset wins, op is dropped.
        valid = 1'b1;
        is_store = 1'b0;
        funct3 = 3'b010;
        addr = 32'h0000_0800;
        @(negedge clk);
        valid = 1'b0;
        checkOutput("rstReq.reqBefore", {31'b0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_ack = 1'b0;
        checkOutput("rstReq.req", {31'b0, dmem_req}, 32'd0);
        checkOutput("rstReq.ready", {31'b0, ready}, 32'd1);
        checkOutput("rstReq.done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstReq.doneAfter", {31'b0, done}, 32'd0);
        @(negedge clk);
        checkOutput("rstReq.idle", {31'b0, ready}, 32'd1);

        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
